// File: rtl/chaos_shift_sequencer.sv
// Avalon-MM queued shift-word sequencer for the chaos key generator.
// Paces queued 32-bit words out over a valid/ready stream at a set interval.
module chaos_shift_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] shift_data,
  output logic        shift_valid,
  input  logic        shift_ready,
  output logic        irq
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] period_q, period_d;
  logic [31:0] last_q, last_d;
  logic [31:0] sdata_q, sdata_d;
  logic        enable_q, enable_d;
  logic        irq_en_q, irq_en_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0] mem_q [FIFO_DEPTH];
  logic [31:0] mem_d [FIFO_DEPTH];

  logic wr_en, wr_shift, wr_ctrl, wr_period, wr_status;
  logic flush, full, empty, pop, accept, push_ok, ovf_set;
  logic [31:0] status;

  assign wr_en     = chipselect & ~write_n;
  assign wr_shift  = wr_en & (address == 2'd0);
  assign wr_ctrl   = wr_en & (address == 2'd1);
  assign wr_period = wr_en & (address == 2'd2);
  assign wr_status = wr_en & (address == 2'd3);
  assign flush     = wr_ctrl & writedata[2];
  assign full      = count_q == CNT_W'(FIFO_DEPTH);
  assign empty     = count_q == '0;

  // A flush in the same cycle blocks the IDLE->WAIT start so WAIT never
  // reaches a pop with an emptied queue.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_q && !empty && !flush) begin
          cnt_d   = period_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!enable_q || flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_ISSUE: begin
        if (shift_ready) begin
          accept  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ovf_set  = wr_shift & ~flush & full & ~pop;
    push_ok  = wr_shift & ~flush & ~ovf_set;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = writedata;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  always_comb begin
    sdata_d  = pop ? mem_q[rd_ptr_q] : sdata_q;
    last_d   = accept ? sdata_q : last_q;
    done_d   = accept | (done_q & ~(wr_status & writedata[12]));
    ovf_d    = ovf_set | (ovf_q & ~(wr_status & writedata[10]));
    enable_d = wr_ctrl ? writedata[0] : enable_q;
    irq_en_d = wr_ctrl ? writedata[1] : irq_en_q;
    period_d = wr_period ? writedata : period_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      last_q   <= '0;
      sdata_q  <= '0;
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      last_q   <= last_d;
      sdata_q  <= sdata_d;
      enable_q <= enable_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  always_comb begin
    status             = '0;
    status[CNT_W-1:0]  = count_q;
    status[8]          = full;
    status[9]          = empty;
    status[10]         = ovf_q;
    status[11]         = state_q != S_IDLE;
    status[12]         = done_q;
    readdata           = '0;
    case (address)
      2'd0:    readdata = last_q;
      2'd1:    readdata = {30'd0, irq_en_q, enable_q};
      2'd2:    readdata = period_q;
      default: readdata = status;
    endcase
  end

  assign shift_data  = sdata_q;
  assign shift_valid = state_q == S_ISSUE;
  assign irq         = irq_en_q & done_q;

endmodule

// File: tb/tb_chaos_shift_sequencer.sv
// Bench for chaos_shift_sequencer: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_chaos_shift_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] shift_data;
  logic        shift_valid;
  logic        shift_ready;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  chaos_shift_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .shift_data(shift_data),
    .shift_valid(shift_valid),
    .shift_ready(shift_ready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words plus an absolute edge number at which
  // the pending issue is due.
  logic [31:0] q[$];
  logic [31:0] m_per, m_last, m_sdata;
  bit          m_en, m_ien, m_ovf, m_done, m_off, m_pend, m_live;
  longint      edge_no = 0;
  longint      m_issue_at;

  always @(posedge clk) begin : model
    bit wr, fl, acc, pop, start, push_ok, ovf_set, clr_d, clr_o;
    edge_no++;
    if (reset) begin
      q.delete();
      m_en = 0; m_ien = 0; m_per = 0; m_ovf = 0; m_done = 0;
      m_last = 0; m_sdata = 0; m_off = 0; m_pend = 0; m_live = 1;
    end else begin
      wr    = chipselect && !write_n;
      fl    = wr && address == 2'd1 && writedata[2];
      clr_d = wr && address == 2'd3 && writedata[12];
      clr_o = wr && address == 2'd3 && writedata[10];
      acc   = m_off && shift_ready;
      pop   = 0;
      start = 0;
      if (m_pend) begin
        if (!m_en || fl) m_pend = 0;
        else if (edge_no == m_issue_at) pop = 1;
      end else if (!m_off && m_en && q.size() != 0 && !fl) begin
        start = 1;
      end
      ovf_set = wr && address == 2'd0 && !fl && q.size() == DEPTH && !pop;
      push_ok = wr && address == 2'd0 && !fl && !ovf_set;
      if (acc) begin
        m_last = m_sdata;
        m_off  = 0;
      end
      if (pop) begin
        m_sdata = q.pop_front();
        m_off   = 1;
        m_pend  = 0;
      end
      if (push_ok) q.push_back(writedata);
      if (fl) q.delete();
      if (start) begin
        m_pend     = 1;
        m_issue_at = edge_no + longint'(m_per) + 1;
      end
      m_done = acc || (m_done && !clr_d);
      m_ovf  = ovf_set || (m_ovf && !clr_o);
      if (wr && address == 2'd1) begin
        m_en  = writedata[0];
        m_ien = writedata[1];
      end
      if (wr && address == 2'd2) m_per = writedata;
    end
  end

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] s;
    s = '0;
    case (a)
      2'd0: s = m_last;
      2'd1: s = {30'd0, m_ien, m_en};
      2'd2: s = m_per;
      default: begin
        s[2:0] = 3'(q.size());
        s[8]   = q.size() == DEPTH;
        s[9]   = q.size() == 0;
        s[10]  = m_ovf;
        s[11]  = m_pend || m_off;
        s[12]  = m_done;
      end
    endcase
    return s;
  endfunction

  always @(posedge clk) begin
    #1;
    if (m_live) begin
      chk("m_valid", {31'd0, shift_valid}, {31'd0, m_off});
      chk("m_data", shift_data, m_sdata);
      chk("m_irq", {31'd0, irq}, {31'd0, m_ien && m_done});
      chk("m_rd", readdata, m_read(address));
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e,
                    input string nm);
    address = a;
    #1;
    chk(nm, readdata, e);
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 20 && !shift_valid; i++) @(negedge clk);
    chk(nm, {31'd0, shift_valid}, 32'd1);
  endtask

  logic [31:0] got[$];
  int          tgot[$];
  logic [31:0] wexp [4];
  int          lat;

  initial begin
    reset       = 1'b1;
    address     = '0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = '0;
    shift_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    rd(2'd0, 32'h0, "rst_shift");
    rd(2'd1, 32'h0, "rst_ctrl");
    rd(2'd2, 32'h0, "rst_period");
    rd(2'd3, 32'h200, "rst_status");
    chk("rst_valid", {31'd0, shift_valid}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // Latency with P = 5
    shift_ready = 1'b1;
    wr(2'd2, 32'd5);
    wr(2'd1, 32'd1);
    wr(2'd0, 32'hA5A5_0001);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (shift_valid) begin
        lat = i;
        break;
      end
    end
    chk("latency", 32'(lat), 32'd7);
    chk("issue_word", shift_data, 32'hA5A5_0001);
    @(negedge clk);
    chk("one_cycle", {31'd0, shift_valid}, 32'd0);
    rd(2'd0, 32'hA5A5_0001, "last_word");
    rd(2'd3, 32'h1200, "done_set");

    // Overflow then ordered draining with P = 0
    wr(2'd3, 32'h1000);
    wr(2'd1, 32'd0);
    for (int i = 0; i < 5; i++) begin
      wexp[i % 4] = 32'h1111_0001 + 32'(i);
      wr(2'd0, 32'h1111_0001 + 32'(i));
    end
    rd(2'd3, 32'h504, "full_ovf");
    wr(2'd2, 32'd0);
    wr(2'd1, 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (shift_valid) begin
        got.push_back(shift_data);
        tgot.push_back(i);
      end
    end
    chk("issue_count", 32'(got.size()), 32'd4);
    for (int j = 0; j < got.size() && j < 4; j++) begin
      chk("order", got[j], 32'h1111_0001 + 32'(j));
      if (j > 0) chk("spacing", 32'(tgot[j] - tgot[j-1]), 32'd3);
    end
    rd(2'd3, 32'h1600, "drained");

    // Stall in ISSUE while disabling and flushing
    shift_ready = 1'b0;
    wr(2'd3, 32'h400);
    wr(2'd0, 32'hDEAD_BEEF);
    wait_valid("stall_start");
    for (int i = 0; i < 10; i++) begin
      if (i == 1) begin
        chipselect = 1'b1; write_n = 1'b0;
        address = 2'd0; writedata = 32'h1234;
      end else if (i == 2) begin
        chipselect = 1'b1; write_n = 1'b0;
        address = 2'd1; writedata = 32'h0;
      end else if (i == 4) begin
        chipselect = 1'b1; write_n = 1'b0;
        address = 2'd1; writedata = 32'h4;
      end
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      chk("stall_valid", {31'd0, shift_valid}, 32'd1);
      chk("stall_data", shift_data, 32'hDEAD_BEEF);
    end
    shift_ready = 1'b1;
    @(negedge clk);
    chk("stall_done", {31'd0, shift_valid}, 32'd0);
    repeat (3) @(negedge clk);
    rd(2'd3, 32'h1200, "stall_idle");
    rd(2'd0, 32'hDEAD_BEEF, "stall_last");

    // Interrupt and clear/set collision
    wr(2'd3, 32'h1000);
    wr(2'd1, 32'd3);
    chk("irq_low", {31'd0, irq}, 32'd0);
    wr(2'd0, 32'h42);
    for (int i = 0; i < 20 && !irq; i++) @(negedge clk);
    chk("irq_rise", {31'd0, irq}, 32'd1);
    wr(2'd3, 32'h1000);
    chk("irq_clear", {31'd0, irq}, 32'd0);
    shift_ready = 1'b0;
    wr(2'd0, 32'h43);
    wait_valid("coll_valid");
    shift_ready = 1'b1;
    wr(2'd3, 32'h1000);
    chk("coll_irq", {31'd0, irq}, 32'd1);
    rd(2'd3, 32'h1200, "coll_done");

    // Reset while a word is offered
    shift_ready = 1'b0;
    wr(2'd0, 32'h77);
    wait_valid("rst_mid_valid");
    reset = 1'b1;
    @(negedge clk);
    chk("rm_valid", {31'd0, shift_valid}, 32'd0);
    chk("rm_data", shift_data, 32'd0);
    chk("rm_irq", {31'd0, irq}, 32'd0);
    rd(2'd1, 32'h0, "rm_ctrl");
    rd(2'd3, 32'h200, "rm_status");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
